// File: rtl/riscv_pkg.sv
// RV32 opcode constants and immediate-format classification shared by the
// immediate datapath and its arbiter.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_NONE
   } imm_fmt_t;

   typedef enum logic {
      SlotEmpty,
      SlotFull
   } slot_state_e;

   function automatic imm_fmt_t opc_fmt(input logic [6:0] opc);
      imm_fmt_t fmt;
      case (opc)
         OPC_LOAD, OPC_OPIMM, OPC_JALR: fmt = FMT_I;
         OPC_STORE:                     fmt = FMT_S;
         OPC_BRANCH:                    fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
         OPC_JAL:                       fmt = FMT_J;
         default:                       fmt = FMT_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32 immediate generator: sign-extended immediate plus a flag
// for opcodes that carry no immediate.
module imm_decode
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] imm,
   output logic            noimm
);

   imm_fmt_t fmt;
   logic     s;

   assign fmt = opc_fmt(instr[6:0]);
   assign s   = instr[31];

   always_comb begin
      imm   = '0;
      noimm = 1'b0;
      unique case (fmt)
         FMT_I:   imm = {{20{s}}, instr[31:20]};
         FMT_S:   imm = {{20{s}}, instr[31:25], instr[11:7]};
         FMT_B:   imm = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm = {instr[31:12], 12'b0};
         FMT_J:   imm = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: noimm = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_share_arbiter.sv
// Round-robin share of one immediate decoder between decode (id 0) and the
// fetch-stage branch-target precompute (id 1), with a single response slot.
module imm_share_arbiter
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   input  logic [XLEN-1:0]  req_instr0,
   input  logic [XLEN-1:0]  req_instr1,
   output logic [1:0]       req_ready,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_imm,
   output logic             resp_id,
   output logic             resp_noimm,
   output logic [CNT_W-1:0] accept_cnt
);

   slot_state_e      state_q, state_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic             id_q, id_d;
   logic             noimm_q, noimm_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             can_accept;
   logic [1:0]       grant;
   logic             grant_id;
   logic             accept;
   logic [XLEN-1:0]  gnt_instr;
   logic [XLEN-1:0]  dec_imm;
   logic             dec_noimm;

   assign can_accept = (state_q == SlotEmpty) || resp_ready;

   // Under contention the requester that did not win last time goes next.
   always_comb begin
      grant = 2'b00;
      if (can_accept) begin
         unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready = grant;
   assign accept    = |grant;
   assign grant_id  = grant[1];
   assign gnt_instr = grant_id ? req_instr1 : req_instr0;

   imm_decode #(
      .XLEN (XLEN)
   ) u_imm_decode (
      .instr (gnt_instr),
      .imm   (dec_imm),
      .noimm (dec_noimm)
   );

   always_comb begin
      state_d      = state_q;
      imm_d        = imm_q;
      id_d         = id_q;
      noimm_d      = noimm_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      if (accept) begin
         state_d      = SlotFull;
         imm_d        = dec_imm;
         id_d         = grant_id;
         noimm_d      = dec_noimm;
         last_grant_d = grant_id;
         cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (state_q == SlotFull && resp_ready) begin
         // Drain keeps the payload; only the occupancy drops.
         state_d = SlotEmpty;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SlotEmpty;
         imm_q        <= '0;
         id_q         <= 1'b0;
         noimm_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         imm_q        <= imm_d;
         id_q         <= id_d;
         noimm_q      <= noimm_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   assign resp_valid = (state_q == SlotFull);
   assign resp_imm   = imm_q;
   assign resp_id    = id_q;
   assign resp_noimm = noimm_q;
   assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_imm_share_arbiter.sv
// Directed self-checking bench for imm_share_arbiter.
module tb_imm_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [31:0] req_instr0;
   logic [31:0] req_instr1;
   logic [1:0]  req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_imm;
   logic        resp_id;
   logic        resp_noimm;
   logic [15:0] accept_cnt;

   int n_checks;
   int n_pass;
   int exp_cnt;

   imm_share_arbiter #(
      .XLEN  (32),
      .CNT_W (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_instr0 (req_instr0),
      .req_instr1 (req_instr1),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_imm   (resp_imm),
      .resp_id    (resp_id),
      .resp_noimm (resp_noimm),
      .accept_cnt (accept_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] dec_instr [6];
   logic [31:0] dec_imm   [6];
   logic        dec_noimm [6];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      exp_cnt  = 0;

      dec_instr[0] = 32'h00000033; dec_imm[0] = 32'h00000000; dec_noimm[0] = 1'b1; // add
      dec_instr[1] = 32'h000010B7; dec_imm[1] = 32'h00001000; dec_noimm[1] = 1'b0; // lui x1,1
      dec_instr[2] = 32'h0080006F; dec_imm[2] = 32'h00000008; dec_noimm[2] = 1'b0; // jal x0,8
      dec_instr[3] = 32'hFFFFF097; dec_imm[3] = 32'hFFFFF000; dec_noimm[3] = 1'b0; // auipc
      dec_instr[4] = 32'h800080E7; dec_imm[4] = 32'hFFFFF800; dec_noimm[4] = 1'b0; // jalr
      dec_instr[5] = 32'h7FF00093; dec_imm[5] = 32'h000007FF; dec_noimm[5] = 1'b0; // addi

      rst_n      = 1'b0;
      req_valid  = 2'b00;
      req_instr0 = '0;
      req_instr1 = '0;
      resp_ready = 1'b0;
      repeat (2) step();

      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_imm", resp_imm, 32'd0);
      check("rst_id", 32'(resp_id), 32'd0);
      check("rst_noimm", 32'(resp_noimm), 32'd0);
      check("rst_cnt", 32'(accept_cnt), 32'd0);
      rst_n = 1'b1;

      // Single load from requester 0.
      req_valid  = 2'b01;
      req_instr0 = 32'hFFC42083;
      #1 check("lw_ready", 32'(req_ready), 32'h1);
      step();
      check("lw_valid", 32'(resp_valid), 32'd1);
      check("lw_imm", resp_imm, 32'hFFFFFFFC);
      check("lw_id", 32'(resp_id), 32'd0);
      check("lw_noimm", 32'(resp_noimm), 32'd0);
      check("lw_cnt", 32'(accept_cnt), 32'd1);

      // Drain without refill keeps the payload.
      req_valid  = 2'b00;
      resp_ready = 1'b1;
      step();
      check("drain_valid", 32'(resp_valid), 32'd0);
      check("drain_imm_hold", resp_imm, 32'hFFFFFFFC);

      // Fresh reset, then contention alternates 0,1,0,1.
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      req_valid  = 2'b11;
      req_instr0 = 32'h00512423;
      req_instr1 = 32'hFE000EE3;
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
         step();
         check("rr_id", 32'(resp_id), 32'(i % 2));
         check("rr_imm", resp_imm, (i % 2 == 0) ? 32'h00000008 : 32'hFFFFFFFC);
      end
      check("rr_cnt", 32'(accept_cnt), 32'd4);

      // Stall: slot held, no grants.
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_ready", 32'(req_ready), 32'h0);
         step();
         check("stall_valid", 32'(resp_valid), 32'd1);
         check("stall_id", 32'(resp_id), 32'd1);
         check("stall_imm", resp_imm, 32'hFFFFFFFC);
      end
      resp_ready = 1'b1;
      #1 check("unstall_ready", 32'(req_ready), 32'h1);
      step();
      check("unstall_id", 32'(resp_id), 32'd0);
      check("unstall_imm", resp_imm, 32'h00000008);
      check("unstall_cnt", 32'(accept_cnt), 32'd5);
      exp_cnt = 5;

      // Decode vectors through requester 0, back to back.
      req_valid = 2'b01;
      for (int i = 0; i < 6; i++) begin
         req_instr0 = dec_instr[i];
         step();
         exp_cnt++;
         check("dec_imm", resp_imm, dec_imm[i]);
         check("dec_noimm", 32'(resp_noimm), 32'(dec_noimm[i]));
      end
      check("dec_cnt", 32'(accept_cnt), 32'(exp_cnt));

      // Counter wrap.
      repeat (32'hFFFF - exp_cnt) step();
      check("cnt_max", 32'(accept_cnt), 32'h0000FFFF);
      step();
      check("cnt_wrap", 32'(accept_cnt), 32'h00000000);

      // Asynchronous reset while full and stalled.
      resp_ready = 1'b0;
      step();
      check("pre_rst_valid", 32'(resp_valid), 32'd1);
      rst_n = 1'b0;
      #1 check("async_rst_valid", 32'(resp_valid), 32'd0);
      check("async_rst_cnt", 32'(accept_cnt), 32'd0);
      check("async_rst_imm", resp_imm, 32'd0);
      rst_n      = 1'b1;
      req_valid  = 2'b11;
      resp_ready = 1'b1;
      #1 check("post_rst_ready", 32'(req_ready), 32'h1);
      step();
      check("post_rst_id", 32'(resp_id), 32'd0);
      check("post_rst_valid", 32'(resp_valid), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
